// File: rtl/logic_analyzer_readout_pkg.sv
// Shared state encoding and parameter legality helpers
// for the logic analyzer readout path.
package logic_analyzer_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } la_state_e;

  function automatic bit la_latency_ok(input int rl);
    return (rl == 1) || (rl == 2);
  endfunction

  function automatic bit la_depth_ok(input int d);
    return (d >= 4) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/logic_analyzer_readout_skid_fifo.sv
// Small output buffer for BRAM read data (N entries, any N).
// Ports: push/din in, pop/dout out, full/empty/count, flush.
module readout_skid_fifo #(
  parameter  int W  = 8,
  parameter  int N  = 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] CAP  = CW'(N);

  logic [W-1:0]  mem [N];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign dout  = mem[rp];
  assign full  = (count == CAP);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < N; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= nxt(wp);
      end
      if (pop)
        rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

  a_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && empty && !flush));

endmodule

// File: rtl/logic_analyzer_readout.sv
// Streams all DEPTH capture samples, oldest first, from the
// circular sample BRAM (read port only) to a valid/ready sink.
// Ports: start/abort/base_addr control, busy/done status,
// bram_addr/bram_en/bram_dout, out_* stream with out_ready.
module logic_analyzer_readout
  import logic_analyzer_readout_pkg::*;
#(
  parameter  int DEPTH        = 1024,
  parameter  int WIDTH        = 32,
  parameter  int READ_LATENCY = 1,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [WIDTH-1:0]      bram_dout,
  output logic [WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int AW  = ADDR_WIDTH;
  localparam int CAP = READ_LATENCY + 1;
  localparam int CW  = $clog2(CAP + 1);
  localparam int EW  = WIDTH + AW + 1;

  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   FINAL_W  = (AW + 1)'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW:0]   CAP_W    = (CW + 1)'(CAP);

  if (!la_latency_ok(READ_LATENCY)) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end

  if (!la_depth_ok(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 4");
  end

  la_state_e state;

  logic                prev_start;
  logic                start_acc;
  logic                issue;
  logic                pop;
  logic                xfer_last;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         issued;
  logic [READ_LATENCY-1:0] fl_vld;
  logic [AW-1:0]       fl_tag [READ_LATENCY];
  logic [CW-1:0]       in_flight;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         used;
  logic                fifo_full;
  logic                fifo_empty;
  logic [EW-1:0]       fifo_din;
  logic [EW-1:0]       fifo_dout;

  assign start_acc = start && !prev_start &&
                     ((state == ST_IDLE) ||
                      (state == ST_DONE));

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      in_flight = in_flight + CW'(fl_vld[i]);
  end

  // A pop this cycle frees its slot for a read issued this
  // cycle, which keeps one sample per cycle in steady state.
  assign pop  = !fifo_empty && out_ready;
  assign used = (CW + 1)'(in_flight) +
                (CW + 1)'(fifo_count) -
                (CW + 1)'(pop);

  assign issue = (state == ST_FETCH) &&
                 (issued < DEPTH_W) &&
                 (used < CAP_W);

  assign bram_en   = issue;
  assign bram_addr = rd_ptr;

  // Each read carries a valid bit and its ordinal; clearing the
  // valid bits on abort squashes data still in the BRAM pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        fl_tag[i] <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        fl_vld[i] <= fl_vld[i-1] && !abort;
        fl_tag[i] <= fl_tag[i-1];
      end
      fl_vld[0] <= issue && !abort;
      fl_tag[0] <= issued[AW-1:0];
    end
  end

  assign fifo_din = {
    (fl_tag[READ_LATENCY-1] == LAST_IDX),
    fl_tag[READ_LATENCY-1],
    bram_dout
  };

  readout_skid_fifo #(
    .W (EW),
    .N (CAP)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (fl_vld[READ_LATENCY-1]),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_dout[WIDTH-1:0];
  assign out_index = fifo_empty ? '0 : fifo_dout[WIDTH +: AW];
  assign out_last  = !fifo_empty && fifo_dout[EW-1];
  assign xfer_last = pop && out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev_start <= 1'b0;
      rd_ptr     <= '0;
      issued     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      prev_start <= start;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start_acc) begin
        state  <= ST_FETCH;
        rd_ptr <= base_addr;
        issued <= '0;
        busy   <= 1'b1;
        done   <= 1'b0;
      end else begin
        if (issue) begin
          rd_ptr <= rd_ptr + 1'b1;
          issued <= issued + 1'b1;
        end
        unique case (state)
          ST_FETCH: begin
            if (issue && (issued == FINAL_W))
              state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (xfer_last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          ST_IDLE, ST_DONE: ;
        endcase
      end
    end
  end

  // Credits cover in-flight reads, so a full buffer means the
  // BRAM pipe is empty.
  a_credit: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(fifo_full && (in_flight != '0)));

endmodule

// File: tb/tb_logic_analyzer_readout.sv
// Directed bench for logic_analyzer_readout at DEPTH=8,
// with one READ_LATENCY=1 and one READ_LATENCY=2 instance.
module tb_logic_analyzer_readout;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          out_ready;
  logic [AW-1:0] base_addr;

  logic          o_busy  [2];
  logic          o_done  [2];
  logic          o_en    [2];
  logic          o_valid [2];
  logic          o_last  [2];
  logic [AW-1:0] o_addr  [2];
  logic [AW-1:0] o_index [2];
  logic [7:0]    o_data  [2];

  logic [7:0] mem [DEPTH];
  logic [7:0] q1;
  logic [7:0] p2;
  logic [7:0] q2;

  int n_chk  = 0;
  int n_fail = 0;

  int m_base [2];
  int m_next [2];
  int m_rd   [2];
  int m_c    [2];
  bit m_busy [2];
  bit m_done [2];
  bit m_prev [2];
  bit m_full [2];
  bit m_stall[2];
  int log_d  [2][16];
  int log_n  [2];
  int exp_a  [8];

  always #5 clk = ~clk;

  logic_analyzer_readout #(
    .DEPTH(8), .WIDTH(8), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .base_addr(base_addr),
    .busy(o_busy[0]), .done(o_done[0]),
    .bram_addr(o_addr[0]), .bram_en(o_en[0]),
    .bram_dout(q1), .out_data(o_data[0]),
    .out_index(o_index[0]), .out_last(o_last[0]),
    .out_valid(o_valid[0]), .out_ready(out_ready)
  );

  logic_analyzer_readout #(
    .DEPTH(8), .WIDTH(8), .READ_LATENCY(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .base_addr(base_addr),
    .busy(o_busy[1]), .done(o_done[1]),
    .bram_addr(o_addr[1]), .bram_en(o_en[1]),
    .bram_dout(q2), .out_data(o_data[1]),
    .out_index(o_index[1]), .out_last(o_last[1]),
    .out_valid(o_valid[1]), .out_ready(out_ready)
  );

  // BRAM models: 1-cycle, and 2-cycle with output register
  always @(posedge clk) begin
    if (o_en[0]) q1 <= mem[o_addr[0]];
    if (o_en[1]) p2 <= mem[o_addr[1]];
    q2 <= p2;
  end

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string name,
                        input int act, input int exp);
    chk(act == exp, name, act, exp);
  endtask

  // Per-cycle model compare: expected sample for ordinal n is
  // mem[(base + n) mod DEPTH] = 0x10 + that address.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int lat;
      int ea;
      bit xfer;
      lat = d + 1;
      if (!rst_n) begin
        m_busy[d]  = 0;
        m_done[d]  = 0;
        m_prev[d]  = 0;
        m_stall[d] = 0;
        m_next[d]  = 0;
        m_rd[d]    = 0;
      end else begin
        chk_eq($sformatf("busy_d%0d", d), o_busy[d], m_busy[d]);
        chk_eq($sformatf("done_d%0d", d), o_done[d], m_done[d]);
        ea = (m_base[d] + m_next[d]) % DEPTH;
        if (o_valid[d]) begin
          chk(m_busy[d], $sformatf("valid_idle_d%0d", d), 1, 0);
          chk_eq($sformatf("data_d%0d", d), o_data[d], 8'h10 + ea);
          chk_eq($sformatf("index_d%0d", d), o_index[d], m_next[d]);
          chk_eq($sformatf("last_d%0d", d), o_last[d],
                 int'(m_next[d] == DEPTH - 1));
        end
        if (m_stall[d])
          chk_eq($sformatf("stall_hold_d%0d", d), o_valid[d], 1);
        if (m_busy[d] && m_c[d] == lat)
          chk_eq($sformatf("early_valid_d%0d", d), o_valid[d], 0);
        if (m_busy[d] && m_full[d] && m_c[d] > lat)
          chk_eq($sformatf("full_rate_d%0d", d), o_valid[d], 1);
        if (o_en[d]) begin
          chk(m_busy[d] && m_rd[d] < DEPTH,
              $sformatf("extra_read_d%0d", d), m_rd[d], DEPTH - 1);
          chk_eq($sformatf("bram_addr_d%0d", d), o_addr[d],
                 (m_base[d] + m_rd[d]) % DEPTH);
        end
        if (m_busy[d])
          chk(m_rd[d] - m_next[d] <= lat + 1,
              $sformatf("credit_d%0d", d),
              m_rd[d] - m_next[d], lat + 1);

        xfer = o_valid[d] && out_ready;
        if (o_en[d]) m_rd[d]++;
        if (abort) begin
          m_busy[d] = 0;
          m_done[d] = 0;
        end else if (start && !m_prev[d] && !m_busy[d]) begin
          m_busy[d] = 1;
          m_done[d] = 0;
          m_base[d] = int'(base_addr);
          m_next[d] = 0;
          m_rd[d]   = 0;
          m_c[d]    = -1;
          m_full[d] = 1;
          log_n[d]  = 0;
        end else if (xfer) begin
          if (log_n[d] < 16) log_d[d][log_n[d]] = int'(o_data[d]);
          log_n[d]++;
          m_next[d]++;
          if (m_next[d] == DEPTH) begin
            m_busy[d] = 0;
            m_done[d] = 1;
          end
        end
        m_prev[d] = start;
        if (m_busy[d]) begin
          m_c[d]++;
          if (!out_ready) m_full[d] = 0;
        end
        m_stall[d] = o_valid[d] && !out_ready && !abort;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    base_addr = b;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit toggle);
    int k = 0;
    while (!(o_done[0] && o_done[1]) && k < 200) begin
      if (toggle) out_ready = (k % 4 == 0) || (k % 4 == 3);
      cyc(1);
      k++;
    end
    out_ready = 1'b1;
    chk(k < 200, {name, "_timeout"}, k, 200);
  endtask

  task automatic wait_log(input string name, input int n);
    int k = 0;
    while (log_n[0] < n && k < 100) begin
      cyc(1);
      k++;
    end
    chk(k < 100, {name, "_timeout"}, k, 100);
  endtask

  task automatic check_log(input string name);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("%s_count_d%0d", name, d), log_n[d], 8);
      for (int i = 0; i < 8; i++)
        chk_eq($sformatf("%s_s%0d_d%0d", name, i, d),
               log_d[d][i], exp_a[i]);
    end
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("%s_busy_d%0d", name, d), o_busy[d], 0);
      chk_eq($sformatf("%s_done_d%0d", name, d), o_done[d], 0);
      chk_eq($sformatf("%s_en_d%0d", name, d), o_en[d], 0);
      chk_eq($sformatf("%s_addr_d%0d", name, d), o_addr[d], 0);
      chk_eq($sformatf("%s_valid_d%0d", name, d), o_valid[d], 0);
      chk_eq($sformatf("%s_last_d%0d", name, d), o_last[d], 0);
      chk_eq($sformatf("%s_index_d%0d", name, d), o_index[d], 0);
      chk_eq($sformatf("%s_data_d%0d", name, d), o_data[d], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int fv0;
    int fv1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h10 + i);
    for (int d = 0; d < 2; d++) log_n[d] = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    base_addr = '0;
    cyc(3);
    check_idle("reset");
    rst_n = 1'b1;
    cyc(2);

    // base 5, ready held high
    pulse_start(3'd5);
    wait_done("s1", 1'b0);
    exp_a = '{'h15, 'h16, 'h17, 'h10, 'h11, 'h12, 'h13, 'h14};
    check_log("s1");
    cyc(1);
    for (int d = 0; d < 2; d++)
      chk_eq($sformatf("s1_done_sticky_d%0d", d), o_done[d], 1);

    // same, ready toggling 1,0,0,1
    pulse_start(3'd5);
    wait_done("s2", 1'b1);
    check_log("s2");
    cyc(2);

    // base 0, first-valid latency per instance
    pulse_start(3'd0);
    k = 0;
    fv0 = -1;
    fv1 = -1;
    while ((fv0 < 0 || fv1 < 0) && k < 20) begin
      if (fv0 < 0 && o_valid[0]) fv0 = k;
      if (fv1 < 0 && o_valid[1]) fv1 = k;
      cyc(1);
      k++;
    end
    chk_eq("lat1_first_valid", fv0, 2);
    chk_eq("lat2_first_valid", fv1, 3);
    wait_done("s3", 1'b0);
    exp_a = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17};
    check_log("s3");
    cyc(2);

    // abort after the third transfer, then restart at 2
    pulse_start(3'd0);
    wait_log("s4_wait", 3);
    abort = 1'b1;
    cyc(1);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("abort_valid_d%0d", d), o_valid[d], 0);
      chk_eq($sformatf("abort_busy_d%0d", d), o_busy[d], 0);
      chk_eq($sformatf("abort_done_d%0d", d), o_done[d], 0);
      chk_eq($sformatf("abort_en_d%0d", d), o_en[d], 0);
    end
    abort = 1'b0;
    cyc(2);
    pulse_start(3'd2);
    wait_done("s4", 1'b0);
    exp_a = '{'h12, 'h13, 'h14, 'h15, 'h16, 'h17, 'h10, 'h11};
    check_log("s4");
    cyc(2);

    // extra start edges while busy are ignored
    pulse_start(3'd3);
    cyc(1);
    pulse_start(3'd6);
    cyc(1);
    start = 1'b1;
    wait_done("s5", 1'b0);
    exp_a = '{'h13, 'h14, 'h15, 'h16, 'h17, 'h10, 'h11, 'h12};
    check_log("s5");
    cyc(5);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("held_busy_d%0d", d), o_busy[d], 0);
      chk_eq($sformatf("held_done_d%0d", d), o_done[d], 1);
    end
    start = 1'b0;
    cyc(1);
    pulse_start(3'd1);
    wait_done("s5b", 1'b0);
    exp_a = '{'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17, 'h10};
    check_log("s5b");
    cyc(2);

    // asynchronous reset late in the readout
    pulse_start(3'd0);
    wait_log("s6_wait", 6);
    out_ready = 1'b0;
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    out_ready = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check_idle("post_reset");
    pulse_start(3'd7);
    wait_done("s6", 1'b0);
    exp_a = '{'h17, 'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16};
    check_log("s6");
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
